uart_alu_bridge: RTL and testbench

UART_ALU_BRIDGE -- requirements
Module: uart_alu_bridge

---
 rtl/uart_alu_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_alu_bridge.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_bridge.sv
// uart_alu_bridge: frames UART bytes into ALU operands and an opcode, and sends
// back a status byte followed, on success, by the result bytes.
//   Frame in : A (NB_BYTES, MSB first), opcode byte, B (NB_BYTES, MSB first)
//   Reply    : 0x00 + result bytes (MSB first) | 0xE1 bad opcode | 0xE2 timeout
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_rx_data/i_rx_done received byte and its done level (rising edge = byte)
//   i_tx_done           TX done level (rising edge = byte sent)
//   i_alu_result        combinational result from the external ALU
//   o_alu_a/b/op        registered operands and translated opcode
//   o_tx_data/start     byte to transmit and its one-cycle request
//   o_busy              high unless idle waiting for the first A byte
//   o_rx_drop           pulse when a received byte is discarded
module uart_alu_bridge #(
  parameter int unsigned NB_DATA  = 8,
  parameter int unsigned NB_BYTES = 2,
  parameter int unsigned NB_OPE   = 6,
  parameter int unsigned TIMEOUT  = 1_000_000
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NB_DATA-1:0]          i_rx_data,
  input  logic                        i_rx_done,
  input  logic                        i_tx_done,
  input  logic [NB_DATA*NB_BYTES-1:0] i_alu_result,
  output logic [NB_DATA*NB_BYTES-1:0] o_alu_a,
  output logic [NB_DATA*NB_BYTES-1:0] o_alu_b,
  output logic [NB_OPE-1:0]           o_alu_op,
  output logic [NB_DATA-1:0]          o_tx_data,
  output logic                        o_tx_start,
  output logic                        o_busy,
  output logic                        o_rx_drop
);

  localparam int unsigned NB_WORD = NB_DATA * NB_BYTES;
  localparam int unsigned NB_CNT  = $clog2(2 * NB_BYTES + 2);
  localparam int unsigned NB_TMO  = $clog2(TIMEOUT);

  localparam logic [NB_CNT-1:0] CNT_A_LAST = NB_CNT'(NB_BYTES - 1);
  localparam logic [NB_CNT-1:0] CNT_B_LAST = NB_CNT'(2 * NB_BYTES);
  localparam logic [NB_CNT-1:0] CNT_RES    = NB_CNT'(NB_BYTES);
  localparam logic [NB_TMO-1:0] TMO_LAST   = NB_TMO'(TIMEOUT - 1);

  localparam logic [NB_DATA-1:0] ST_OK  = NB_DATA'(8'h00);
  localparam logic [NB_DATA-1:0] ST_INV = NB_DATA'(8'hE1);
  localparam logic [NB_DATA-1:0] ST_TMO = NB_DATA'(8'hE2);

  typedef enum logic [2:0] {
    S_RX_A,
    S_RX_OP,
    S_RX_B,
    S_EXEC,
    S_TX_LOAD,
    S_TX_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [NB_TMO-1:0]   tmo_q, tmo_d;
  logic [NB_WORD-1:0]  a_q, a_d;
  logic [NB_WORD-1:0]  b_q, b_d;
  logic [NB_WORD-1:0]  res_q, res_d;
  logic [NB_OPE-1:0]   op_q, op_d;
  logic                inv_q, inv_d;
  logic                send_q, send_d;
  logic [NB_DATA-1:0]  tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic                rx_drop_q, rx_drop_d;
  logic                rx_done_q;
  logic                tx_done_q;
  logic                rx_arm_q;
  logic                rx_edge_c;
  logic                tx_edge_c;
  logic                in_rx_c;

  // rx_arm_q masks the first cycle after reset so a level already high is not a byte
  assign rx_edge_c = i_rx_done & ~rx_done_q & rx_arm_q;
  assign tx_edge_c = i_tx_done & ~tx_done_q;
  assign in_rx_c   = (state_q == S_RX_A) || (state_q == S_RX_OP) || (state_q == S_RX_B);

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_RX_A;
      cnt_q      <= '0;
      tmo_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      op_q       <= '0;
      inv_q      <= 1'b0;
      send_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_drop_q  <= 1'b0;
      rx_done_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_arm_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      op_q       <= op_d;
      inv_q      <= inv_d;
      send_q     <= send_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      rx_drop_q  <= rx_drop_d;
      rx_done_q  <= i_rx_done;
      tx_done_q  <= i_tx_done;
      rx_arm_q   <= 1'b1;
    end
  end

  // Next-state and output logic; cnt_q counts frame bytes on RX and result bytes on TX
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = '0;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    op_d       = op_q;
    inv_d      = inv_q;
    send_d     = send_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    rx_drop_d  = 1'b0;

    case (state_q)
      S_RX_A: begin
        if (rx_edge_c) begin
          a_d   = (a_q << NB_DATA) | NB_WORD'(i_rx_data);
          cnt_d = cnt_q + NB_CNT'(1);
          if (cnt_q == CNT_A_LAST) state_d = S_RX_OP;
        end
      end
      S_RX_OP: begin
        if (rx_edge_c) begin
          inv_d = 1'b0;
          case (i_rx_data)
            NB_DATA'(8'h2B): op_d = NB_OPE'(6'b100000);
            NB_DATA'(8'h2D): op_d = NB_OPE'(6'b100010);
            NB_DATA'(8'h26): op_d = NB_OPE'(6'b100100);
            NB_DATA'(8'h7C): op_d = NB_OPE'(6'b100101);
            NB_DATA'(8'h5E): op_d = NB_OPE'(6'b100110);
            default: begin
              op_d  = '0;
              inv_d = 1'b1;
            end
          endcase
          cnt_d   = cnt_q + NB_CNT'(1);
          state_d = S_RX_B;
        end
      end
      S_RX_B: begin
        if (rx_edge_c) begin
          b_d   = (b_q << NB_DATA) | NB_WORD'(i_rx_data);
          cnt_d = cnt_q + NB_CNT'(1);
          if (cnt_q == CNT_B_LAST) state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d      = i_alu_result;
        send_d     = ~inv_q;
        cnt_d      = '0;
        tx_data_d  = inv_q ? ST_INV : ST_OK;
        tx_start_d = 1'b1;
        state_d    = S_TX_LOAD;
      end
      S_TX_LOAD: begin
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_edge_c) begin
          if (send_q && (cnt_q < CNT_RES)) begin
            // Result is shifted out MSB first from the top of res_q
            tx_data_d  = res_q[NB_WORD-1 -: NB_DATA];
            res_d      = res_q << NB_DATA;
            cnt_d      = cnt_q + NB_CNT'(1);
            tx_start_d = 1'b1;
            state_d    = S_TX_LOAD;
          end else begin
            cnt_d   = '0;
            state_d = S_RX_A;
          end
        end
      end
      default: begin
        state_d = S_RX_A;
        cnt_d   = '0;
      end
    endcase

    // Inter-byte timeout on a partial frame; an arriving byte takes priority
    if (in_rx_c && (cnt_q != '0) && !rx_edge_c) begin
      if (tmo_q == TMO_LAST) begin
        state_d    = S_TX_LOAD;
        cnt_d      = '0;
        send_d     = 1'b0;
        inv_d      = 1'b0;
        tx_data_d  = ST_TMO;
        tx_start_d = 1'b1;
      end else begin
        tmo_d = tmo_q + NB_TMO'(1);
      end
    end

    if (!in_rx_c && rx_edge_c) rx_drop_d = 1'b1;
  end

  assign busy_d = !((state_d == S_RX_A) && (cnt_d == '0));

  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_alu_op   = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_rx_drop  = rx_drop_q;

endmodule

// File: tb/tb_uart_alu_bridge.sv
// Directed bench for uart_alu_bridge (NB_BYTES=2, short TIMEOUT).
module tb_uart_alu_bridge;

  localparam int unsigned NB_DATA  = 8;
  localparam int unsigned NB_BYTES = 2;
  localparam int unsigned NB_OPE   = 6;
  localparam int unsigned TIMEOUT  = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_done = 1'b0;
  logic [15:0] alu_res;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [5:0]  alu_op;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        rx_drop;

  int          checks    = 0;
  int          errors    = 0;
  int          cyc       = 0;
  int          drop_cnt  = 0;
  int          last_rise = 0;
  int          exp_lat   = 0;
  bit          lat_chk   = 1'b0;
  int          tx_timer  = 0;
  logic [7:0]  last_tx   = 8'h00;
  logic [7:0]  exp_q[$];
  logic [7:0]  log_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU, driven by the opcode encoding the bridge emits
  function automatic logic [15:0] ext_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      default:   return 16'h0000;
    endcase
  endfunction

  assign alu_res = ext_alu(alu_a, alu_b, alu_op);

  uart_alu_bridge #(
    .NB_DATA (NB_DATA),
    .NB_BYTES(NB_BYTES),
    .NB_OPE  (NB_OPE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .i_tx_done   (tx_done),
    .i_alu_result(alu_res),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_alu_op    (alu_op),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .o_busy      (busy),
    .o_rx_drop   (rx_drop)
  );

  // UART TX stand-in: done level rises 4 cycles after each start request
  always @(negedge clk) begin
    if (tx_start) begin
      tx_done  = 1'b0;
      tx_timer = 4;
    end else if (tx_timer != 0) begin
      tx_timer = tx_timer - 1;
      if (tx_timer == 0) tx_done = 1'b1;
    end
  end

  // Compare process: every transmitted byte against the model queue, data held otherwise
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      last_tx = 8'h00;
    end else begin
      if (rx_drop) drop_cnt = drop_cnt + 1;
      checks = checks + 1;
      if (tx_start) begin
        log_q.push_back(tx_data);
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL tx_byte: unexpected start with data %h, no byte required", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors = errors + 1;
            $display("FAIL tx_byte: got %h required %h", tx_data, e);
          end
        end
        if (lat_chk) begin
          lat_chk = 1'b0;
          checks  = checks + 1;
          if (cyc - last_rise != exp_lat) begin
            errors = errors + 1;
            $display("FAIL start_latency: got %0d required %0d", cyc - last_rise, exp_lat);
          end
        end
        last_tx = tx_data;
      end else if (tx_data !== last_tx) begin
        errors = errors + 1;
        $display("FAIL tx_hold: got %h required %h", tx_data, last_tx);
      end
    end
  end

  // Frame-level model: expected reply bytes from operands and the ASCII opcode
  task automatic expect_frame(input logic [15:0] a, input logic [7:0] op, input logic [15:0] b);
    logic [15:0] r;
    bit          ok;
    ok = 1'b1;
    r  = 16'h0000;
    case (op)
      8'h2B:   r = a + b;
      8'h2D:   r = a - b;
      8'h26:   r = a & b;
      8'h7C:   r = a | b;
      8'h5E:   r = a ^ b;
      default: ok = 1'b0;
    endcase
    if (ok) begin
      exp_q.push_back(8'h00);
      exp_q.push_back(r[15:8]);
      exp_q.push_back(r[7:0]);
    end else begin
      exp_q.push_back(8'hE1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data   = b;
    rx_done   = 1'b1;
    last_rise = cyc;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [7:0] op, input logic [15:0] b,
                            input int hold0);
    expect_frame(a, op, b);
    send_byte(a[15:8], hold0);
    send_byte(a[7:0], 2);
    send_byte(op, 2);
    send_byte(b[15:8], 2);
    exp_lat = 2;
    lat_chk = 1'b1;
    send_byte(b[7:0], 2);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 1;
    if (exp_q.size() != 0 || busy) begin
      errors = errors + 1;
      $display("FAIL %s_done: %0d bytes owed busy %0b, required 0 and 0", name, exp_q.size(), busy);
      exp_q.delete();
    end
    lat_chk = 1'b0;
  endtask

  task automatic check_log(input string name, input int n,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] e[3];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    checks = checks + 1;
    if (log_q.size() != n) begin
      errors = errors + 1;
      $display("FAIL %s_count: got %0d bytes required %0d", name, log_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks = checks + 1;
        if (log_q[i] !== e[i]) begin
          errors = errors + 1;
          $display("FAIL %s_byte%0d: got %h required %h", name, i, log_q[i], e[i]);
        end
      end
    end
    log_q.delete();
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int base;
    rst     = 1'b1;
    rx_done = 1'b1;
    rx_data = 8'hAA;
    repeat (3) @(negedge clk);
    check_val("rst_tx_start", 32'(tx_start), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_rx_drop", 32'(rx_drop), 32'h0);
    check_val("rst_tx_data", 32'(tx_data), 32'h0);
    check_val("rst_alu_a", 32'(alu_a), 32'h0);
    check_val("rst_alu_b", 32'(alu_b), 32'h0);
    check_val("rst_alu_op", 32'(alu_op), 32'h0);

    // rx_done already high as reset releases must not count as a byte
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_val("stuck_rx_busy", 32'(busy), 32'h0);
    rx_done = 1'b0;
    @(negedge clk);

    send_frame(16'h1234, 8'h2B, 16'h0F0F, 2);
    wait_idle("add");
    check_log("add", 3, 8'h00, 8'h21, 8'h43);
    check_val("add_alu_a", 32'(alu_a), 32'h1234);
    check_val("add_alu_b", 32'(alu_b), 32'h0F0F);
    check_val("add_alu_op", 32'(alu_op), 32'h20);

    send_frame(16'h0001, 8'h2D, 16'h0002, 2);
    wait_idle("sub_wrap");
    check_log("sub_wrap", 3, 8'h00, 8'hFF, 8'hFF);
    check_val("sub_alu_op", 32'(alu_op), 32'h22);

    send_frame(16'h0005, 8'h2A, 16'h0003, 2);
    wait_idle("bad_op");
    check_log("bad_op", 1, 8'hE1, 8'h00, 8'h00);
    check_val("bad_alu_op", 32'(alu_op), 32'h0);

    send_frame(16'hA5A5, 8'h26, 16'h0FF0, 2);
    wait_idle("and");
    check_log("and", 3, 8'h00, 8'h05, 8'hA0);
    send_frame(16'h1200, 8'h7C, 16'h0034, 2);
    wait_idle("or");
    check_log("or", 3, 8'h00, 8'h12, 8'h34);
    send_frame(16'hFFFF, 8'h5E, 16'h00FF, 2);
    wait_idle("xor");
    check_log("xor", 3, 8'h00, 8'hFF, 8'h00);

    // Single byte then silence: timeout status alone
    exp_q.push_back(8'hE2);
    exp_lat = int'(TIMEOUT) + 1;
    lat_chk = 1'b1;
    send_byte(8'h12, 2);
    check_val("tmo_busy", 32'(busy), 32'h1);
    wait_idle("timeout");
    check_log("timeout", 1, 8'hE2, 8'h00, 8'h00);
    send_frame(16'h0102, 8'h2B, 16'h0304, 2);
    wait_idle("post_tmo");
    check_log("post_tmo", 3, 8'h00, 8'h04, 8'h06);

    // Next byte lands on the very cycle the timeout would fire: byte wins
    expect_frame(16'h1234, 8'h2B, 16'h0001);
    send_byte(8'h12, 2);
    k = last_rise;
    while (cyc < k + int'(TIMEOUT)) @(negedge clk);
    send_byte(8'h34, 2);
    send_byte(8'h2B, 2);
    send_byte(8'h00, 2);
    exp_lat = 2;
    lat_chk = 1'b1;
    send_byte(8'h01, 2);
    wait_idle("tmo_race");
    check_log("tmo_race", 3, 8'h00, 8'h12, 8'h35);

    // RX edge while a reply is in flight is dropped
    base = drop_cnt;
    send_frame(16'h0303, 8'h2D, 16'h0101, 2);
    n = 0;
    while (log_q.size() < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    send_byte(8'h55, 2);
    wait_idle("drop");
    check_log("drop", 3, 8'h00, 8'h02, 8'h02);
    check_val("drop_pulses", 32'(drop_cnt - base), 32'h1);

    // Long rx_done level yields one byte
    send_frame(16'h0010, 8'h2B, 16'h0020, 20);
    wait_idle("long_hold");
    check_log("long_hold", 3, 8'h00, 8'h00, 8'h30);

    // Reset while the second result byte is pending
    send_frame(16'h4321, 8'h2D, 16'h0021, 2);
    n = 0;
    while (log_q.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("mid_rst_started", 32'(log_q.size()), 32'h2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    lat_chk = 1'b0;
    rst = 1'b0;
    log_q.delete();
    repeat (20) @(negedge clk);
    check_val("mid_rst_starts", 32'(log_q.size()), 32'h0);
    check_val("mid_rst_busy", 32'(busy), 32'h0);
    check_val("mid_rst_tx_data", 32'(tx_data), 32'h0);
    send_frame(16'h0001, 8'h2B, 16'h0001, 2);
    wait_idle("post_rst");
    check_log("post_rst", 3, 8'h00, 8'h00, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
